// File: rtl/lockin_pkg.sv
// Shared definitions for the lookup-SRAM arbiter: FSM states, read tag
// layout and default bus widths.
package lockin_pkg;

    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_DW = 16;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    function automatic rd_tag_t make_tag(input logic gnt_a, input logic gnt_b);
        rd_tag_t t;
        t.valid = gnt_a | gnt_b;
        t.port  = gnt_b ? PORT_B : PORT_A;
        return t;
    endfunction

endpackage

// File: rtl/sram_rd_tagpipe.sv
// Read-return path: delays each read tag by the SRAM latency, then captures
// sram_dout into the owning port's rdata register and pulses its rvalid.
module sram_rd_tagpipe
    import lockin_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_tag,
    input  logic [DW-1:0] i_dout,
    output logic          o_ra_rvalid,
    output logic [DW-1:0] o_ra_rdata,
    output logic          o_rb_rvalid,
    output logic [DW-1:0] o_rb_rdata
);

    rd_tag_t       r_tag [RD_LAT];
    rd_tag_t       w_tag_in;
    rd_tag_t       w_tag_out;
    logic          w_hit_a;
    logic          w_hit_b;
    logic          r_ra_rvalid;
    logic          r_rb_rvalid;
    logic [DW-1:0] r_ra_rdata;
    logic [DW-1:0] r_rb_rdata;

    assign w_tag_in  = i_tag;
    assign w_tag_out = r_tag[RD_LAT-1];
    assign w_hit_a   = w_tag_out.valid && (w_tag_out.port == PORT_A);
    assign w_hit_b   = w_tag_out.valid && (w_tag_out.port == PORT_B);

    // Shifts every cycle regardless of arbiter state so in-flight reads always land.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ra_rvalid <= 1'b0;
            r_rb_rvalid <= 1'b0;
            r_ra_rdata  <= '0;
            r_rb_rdata  <= '0;
        end else begin
            r_ra_rvalid <= w_hit_a;
            r_rb_rvalid <= w_hit_b;
            if (w_hit_a) begin
                r_ra_rdata <= i_dout;
            end
            if (w_hit_b) begin
                r_rb_rdata <= i_dout;
            end
        end
    end

    assign o_ra_rvalid = r_ra_rvalid;
    assign o_rb_rvalid = r_rb_rvalid;
    assign o_ra_rdata  = r_ra_rdata;
    assign o_rb_rdata  = r_rb_rdata;

endmodule

// File: rtl/sram_arbiter.sv
// Single-port lookup SRAM arbiter: boot sequencing around the flash loader,
// write-priority grants, round-robin A/B reads and tagged read return.
module sram_arbiter
    import lockin_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          CLK36,
    input  logic          rst,
    input  logic          wr_lock,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          ra_req,
    input  logic [AW-1:0] ra_addr,
    output logic          ra_gnt,
    output logic          ra_rvalid,
    output logic [DW-1:0] ra_rdata,
    input  logic          rb_req,
    input  logic [AW-1:0] rb_addr,
    output logic          rb_gnt,
    output logic          rb_rvalid,
    output logic [DW-1:0] rb_rdata,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_dout,
    output logic          ready
);

    // DRAIN lasts RD_LAT+1 cycles: the counter runs RD_LAT down to 0.
    localparam logic [1:0] LAT_CNT = 2'(RD_LAT);

    arb_state_e r_state;
    logic [1:0] r_cnt;
    logic       r_ready;
    logic       r_rr;
    logic       w_wr_ok;
    logic       w_rd_ok;
    logic       w_wr_gnt;
    logic       w_ra_gnt;
    logic       w_rb_gnt;
    rd_tag_t    w_tag;

    always_ff @(posedge CLK36 or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (wr_lock) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!wr_lock) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= LAT_CNT;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 2'd0) begin
                        if (wr_lock) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_RUN: begin
                    if (wr_lock) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= LAT_CNT;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign w_wr_ok  = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign w_wr_gnt = wr_req && w_wr_ok;
    assign w_rd_ok  = (r_state == ST_RUN) && !w_wr_gnt;
    assign w_ra_gnt = w_rd_ok && ra_req && (!rb_req || (r_rr == PORT_A));
    assign w_rb_gnt = w_rd_ok && rb_req && (!ra_req || (r_rr == PORT_B));

    // Pointer flips on every read grant, including a lone requester's.
    always_ff @(posedge CLK36 or posedge rst) begin
        if (rst) begin
            r_rr <= PORT_A;
        end else if (w_ra_gnt || w_rb_gnt) begin
            r_rr <= ~r_rr;
        end
    end

    always_comb begin
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_wr_gnt) begin
            sram_wen   = 1'b1;
            sram_addr  = wr_addr;
            sram_wdata = wr_data;
        end else if (w_ra_gnt) begin
            sram_addr = ra_addr;
        end else if (w_rb_gnt) begin
            sram_addr = rb_addr;
        end
    end

    assign w_tag = make_tag(w_ra_gnt, w_rb_gnt);

    sram_rd_tagpipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_tagpipe (
        .i_clk       (CLK36),
        .i_rst       (rst),
        .i_tag       (w_tag),
        .i_dout      (sram_dout),
        .o_ra_rvalid (ra_rvalid),
        .o_ra_rdata  (ra_rdata),
        .o_rb_rvalid (rb_rvalid),
        .o_rb_rdata  (rb_rdata)
    );

    assign wr_gnt = w_wr_gnt;
    assign ra_gnt = w_ra_gnt;
    assign rb_gnt = w_rb_gnt;
    assign ready  = r_ready;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (RD_LAT 1..3) share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_sram_arbiter;

    localparam int NI     = 3;
    localparam int MBOOT  = 0;
    localparam int MLOAD  = 1;
    localparam int MDRAIN = 2;
    localparam int MRUN   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     = 1'b0;
    logic        wr_lock = 1'b0;
    logic        wr_req  = 1'b0;
    logic        ra_req  = 1'b0;
    logic        rb_req  = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] ra_addr = '0;
    logic [15:0] rb_addr = '0;

    logic [NI-1:0] wr_gnt, ra_gnt, rb_gnt, ra_rvalid, rb_rvalid, sram_wen, ready;
    logic [15:0]   ra_rdata [NI];
    logic [15:0]   rb_rdata [NI];
    logic [15:0]   sram_addr [NI];
    logic [15:0]   sram_wdata [NI];
    logic [15:0]   sram_dout [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [15:0] mem [16];
        logic [15:0] pipe [3];

        sram_arbiter #(
            .AW     (16),
            .DW     (16),
            .RD_LAT (g + 1)
        ) u_dut (
            .CLK36      (clk),
            .rst        (rst),
            .wr_lock    (wr_lock),
            .wr_req     (wr_req),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .wr_gnt     (wr_gnt[g]),
            .ra_req     (ra_req),
            .ra_addr    (ra_addr),
            .ra_gnt     (ra_gnt[g]),
            .ra_rvalid  (ra_rvalid[g]),
            .ra_rdata   (ra_rdata[g]),
            .rb_req     (rb_req),
            .rb_addr    (rb_addr),
            .rb_gnt     (rb_gnt[g]),
            .rb_rvalid  (rb_rvalid[g]),
            .rb_rdata   (rb_rdata[g]),
            .sram_wen   (sram_wen[g]),
            .sram_addr  (sram_addr[g]),
            .sram_wdata (sram_wdata[g]),
            .sram_dout  (sram_dout[g]),
            .ready      (ready[g])
        );

        // 16x16 SRAM with g+1 cycles from address to dout.
        always @(posedge clk) begin
            if (sram_wen[g]) mem[sram_addr[g][3:0]] <= sram_wdata[g];
            pipe[0] <= mem[sram_addr[g][3:0]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign sram_dout[g] = pipe[g];
    end

    typedef struct {
        int          k;
        int          due;
        logic        port;
        logic [15:0] data;
    } ret_t;

    ret_t        rq[$];
    int          mode [NI];
    int          drain_until [NI];
    logic        rr [NI];
    logic [15:0] mref [NI][16];
    logic [15:0] exp_ra [NI];
    logic [15:0] exp_rb [NI];
    logic        eg_a [NI];
    logic        eg_b [NI];
    int          cyc;
    int          n_vec;
    int          n_err;

    task automatic cmp(input string name, input int k, input logic [47:0] obs,
                       input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h", name, k + 1, cyc, obs,
                   exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            logic        ew, ea, eb, rva, rvb;
            logic [15:0] eaddr, ewd;
            int          i;
            ret_t        r;
            if (rst) begin
                mode[k]   = MBOOT;
                rr[k]     = 1'b0;
                exp_ra[k] = '0;
                exp_rb[k] = '0;
            end
            ew = wr_req && (mode[k] == MLOAD || mode[k] == MRUN);
            ea = 1'b0;
            eb = 1'b0;
            if (mode[k] == MRUN && !ew) begin
                if (ra_req && rb_req) begin
                    ea = !rr[k];
                    eb = rr[k];
                end else begin
                    ea = ra_req;
                    eb = rb_req;
                end
            end
            eaddr = ew ? wr_addr : ea ? ra_addr : eb ? rb_addr : 16'h0;
            ewd   = ew ? wr_data : 16'h0;
            rva   = 1'b0;
            rvb   = 1'b0;
            i     = 0;
            while (i < rq.size()) begin
                if (rq[i].k == k && (rst || rq[i].due == cyc)) begin
                    if (!rst) begin
                        if (rq[i].port) begin
                            rvb       = 1'b1;
                            exp_rb[k] = rq[i].data;
                        end else begin
                            rva       = 1'b1;
                            exp_ra[k] = rq[i].data;
                        end
                    end
                    rq.delete(i);
                end else begin
                    i++;
                end
            end
            cmp("grant", k, 48'({wr_gnt[k], ra_gnt[k], rb_gnt[k]}), 48'({ew, ea, eb}));
            cmp("sram", k, 48'({sram_wen[k], sram_addr[k], sram_wdata[k]}),
                48'({ew, eaddr, ewd}));
            cmp("ready", k, 48'(ready[k]), 48'(mode[k] == MRUN));
            cmp("rdret", k, 48'({ra_rvalid[k], rb_rvalid[k], ra_rdata[k], rb_rdata[k]}),
                48'({rva, rvb, exp_ra[k], exp_rb[k]}));
            eg_a[k] = ea;
            eg_b[k] = eb;
            if (!rst) begin
                if (ew) mref[k][wr_addr[3:0]] = wr_data;
                if (ea || eb) begin
                    r.k    = k;
                    r.due  = cyc + k + 2;
                    r.port = eb;
                    r.data = mref[k][eaddr[3:0]];
                    rq.push_back(r);
                    rr[k] = !rr[k];
                end
            end
        end
    endtask

    task automatic update();
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                mode[k] = MBOOT;
                rr[k]   = 1'b0;
            end else begin
                case (mode[k])
                    MBOOT: if (wr_lock) mode[k] = MLOAD;
                    MLOAD: if (!wr_lock) begin
                        mode[k]        = MDRAIN;
                        drain_until[k] = cyc + k + 2;
                    end
                    MDRAIN: if (cyc == drain_until[k]) mode[k] = wr_lock ? MLOAD : MRUN;
                    default: if (wr_lock) begin
                        mode[k]        = MDRAIN;
                        drain_until[k] = cyc + k + 2;
                    end
                endcase
            end
        end
    endtask

    task automatic step(input int n);
        for (int s = 0; s < n; s++) begin
            #1;
            check_all();
            @(posedge clk);
            update();
            @(negedge clk);
        end
    endtask

    initial begin
        cyc   = 0;
        n_vec = 0;
        n_err = 0;
        for (int k = 0; k < NI; k++) begin
            mode[k]   = MBOOT;
            rr[k]     = 1'b0;
            exp_ra[k] = '0;
            exp_rb[k] = '0;
            for (int a = 0; a < 16; a++) mref[k][a] = '0;
        end
        @(negedge clk);
        rst = 1'b1;
        step(2);
        rst = 1'b0;

        // Boot: pending read is refused until the table is loaded.
        ra_req  = 1'b1;
        ra_addr = 16'h0010;
        step(3);
        wr_req  = 1'b1;
        wr_addr = 16'h0003;
        wr_data = 16'h1234;
        step(1);
        wr_req  = 1'b0;
        wr_lock = 1'b1;
        step(1);
        wr_req  = 1'b1;
        wr_addr = 16'h0010;
        wr_data = 16'hBEEF;
        step(1);
        wr_req  = 1'b0;
        step(1);
        wr_lock = 1'b0;
        step(8);
        ra_req = 1'b0;
        step(5);

        // Async reset with one read in flight.
        ra_req = 1'b1;
        step(1);
        ra_req = 1'b0;
        rst    = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);

        // Fill the table, then try a write while draining.
        wr_lock = 1'b1;
        step(1);
        for (int a = 0; a < 16; a++) begin
            wr_req  = 1'b1;
            wr_addr = 16'(a);
            wr_data = 16'($urandom);
            step(1);
        end
        wr_lock = 1'b0;
        wr_addr = 16'h0005;
        wr_data = 16'hA5A5;
        step(2);
        wr_req = 1'b0;
        step(6);

        // Round-robin between A and B.
        ra_req  = 1'b1;
        ra_addr = 16'h0001;
        rb_req  = 1'b1;
        rb_addr = 16'h0002;
        step(8);
        ra_req = 1'b0;
        rb_req = 1'b0;
        step(5);

        // All three at once: write wins, reads follow in RR order.
        wr_req  = 1'b1;
        wr_addr = 16'h0003;
        wr_data = 16'h5A5A;
        ra_req  = 1'b1;
        ra_addr = 16'h0004;
        rb_req  = 1'b1;
        rb_addr = 16'h0003;
        step(1);
        wr_req = 1'b0;
        step(3);
        ra_req = 1'b0;
        rb_req = 1'b0;
        step(5);

        // Reload with a read in flight, plus a lock bounce inside DRAIN.
        rb_req  = 1'b1;
        rb_addr = 16'h0007;
        step(1);
        rb_req  = 1'b0;
        wr_lock = 1'b1;
        step(6);
        wr_req  = 1'b1;
        wr_addr = 16'h0007;
        wr_data = 16'hC0DE;
        step(1);
        wr_req  = 1'b0;
        wr_lock = 1'b0;
        step(1);
        wr_lock = 1'b1;
        step(6);
        wr_lock = 1'b0;
        step(6);

        // Back-to-back sweep of all addresses on each port.
        for (int a = 0; a < 32; a++) begin
            ra_req  = (a < 16);
            rb_req  = (a >= 16);
            ra_addr = 16'(a);
            rb_addr = 16'(a - 16);
            step(1);
        end
        ra_req = 1'b0;
        rb_req = 1'b0;
        step(5);

        // Random traffic; readers hold until granted.
        for (int t = 0; t < 400; t++) begin
            if (!ra_req || eg_a[0]) begin
                ra_req  = ($urandom_range(0, 2) != 0);
                ra_addr = 16'($urandom);
            end
            if (!rb_req || eg_b[0]) begin
                rb_req  = ($urandom_range(0, 2) != 0);
                rb_addr = 16'($urandom);
            end
            wr_req  = ($urandom_range(0, 7) == 0);
            wr_addr = 16'($urandom);
            wr_data = 16'($urandom);
            step(1);
        end
        ra_req = 1'b0;
        rb_req = 1'b0;
        wr_req = 1'b0;
        step(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
